// File: rtl/fetch_pkg.sv
// Shared constants, counter type and immediate decoders for the fetch stage.
// Used by fetch_unit and branch_history_table (FETCH_BHT_EN build only).
package fetch_pkg;

   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_t;

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_unit_branch_history_table.sv
// Array of 2-bit saturating counters: async reset to weakly not-taken,
// combinational read port, synchronous training port (read-before-write).
module branch_history_table
   import fetch_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx,
   output bht_ctr_t                   rd_ctr,
   input  logic                       upd_en,
   input  logic [$clog2(ENTRIES)-1:0] upd_idx,
   input  logic                       upd_taken
);

   bht_ctr_t ctr_r [ENTRIES];

   function automatic bht_ctr_t ctr_step(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t res;
      case (ctr)
         SNT:     res = taken ? WNT : SNT;
         WNT:     res = taken ? WT  : SNT;
         WT:      res = taken ? ST  : WNT;
         ST:      res = taken ? ST  : WT;
         default: res = WNT;
      endcase
      return res;
   endfunction

   // Counter storage with saturating training
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_r[i] <= WNT;
         end
      end else if (upd_en) begin
         ctr_r[upd_idx] <= ctr_step(ctr_r[upd_idx], upd_taken);
      end
   end

   assign rd_ctr = ctr_r[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, predecode of B-type/JAL and next-PC selection.
// FETCH_BHT_EN selects BHT-based branch prediction; otherwise static BTFN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BHT_ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        redirect_E,
   input  logic [31:0] redirect_pc_E,
   input  logic        bht_update_E,
   input  logic [31:0] bht_pc_E,
   input  logic        bht_taken_E,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic [31:0] InstrF,
   output logic        predict_taken_F
);

   logic [31:0] pc_r;
   logic [31:0] pc_plus4_s;
   logic [31:0] instr_s;
   logic [31:0] target_s;
   logic [31:0] next_pc_s;
   logic [6:0]  opcode_s;
   logic        is_branch_s;
   logic        is_jal_s;
   logic        branch_hint_s;
   logic        predict_s;

`ifdef FETCH_BHT_EN
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   bht_ctr_t lookup_ctr_s;
   logic     unused_bht_s;

   branch_history_table #(
      .ENTRIES (BHT_ENTRIES)
   ) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc_r[IDX_W+1:2]),
      .rd_ctr    (lookup_ctr_s),
      .upd_en    (bht_update_E),
      .upd_idx   (bht_pc_E[IDX_W+1:2]),
      .upd_taken (bht_taken_E)
   );

   assign branch_hint_s = lookup_ctr_s[1];
   assign unused_bht_s  = ^bht_pc_E;
`else
   logic unused_bht_s;

   // Backward branches (negative offset) are predicted taken
   assign branch_hint_s = instr_s[31];
   assign unused_bht_s  = ^{bht_update_E, bht_pc_E, bht_taken_E, (BHT_ENTRIES > 1)};
`endif

   // Instruction word is a NOP while reset is held
   always_comb begin
      if (!rst) begin
         instr_s = NOP_INSTR;
      end else begin
         instr_s = imem_rdata;
      end
   end

   // Predecode and prediction
   always_comb begin
      opcode_s    = instr_s[6:0];
      is_branch_s = (opcode_s == OPC_BRANCH);
      is_jal_s    = (opcode_s == OPC_JAL);
      predict_s   = is_jal_s | (is_branch_s & branch_hint_s);
      pc_plus4_s  = pc_r + 32'd4;
      if (is_jal_s) begin
         target_s = pc_r + imm_j(instr_s);
      end else begin
         target_s = pc_r + imm_b(instr_s);
      end
   end

   // Next-PC priority: redirect, stall, predicted target, sequential
   always_comb begin
      if (redirect_E) begin
         next_pc_s = redirect_pc_E;
      end else if (!en) begin
         next_pc_s = pc_r;
      end else if (predict_s) begin
         next_pc_s = target_s;
      end else begin
         next_pc_s = pc_plus4_s;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= next_pc_s;
      end
   end

   assign imem_addr       = pc_r;
   assign PCF             = pc_r;
   assign PCPlus4F        = pc_plus4_s;
   assign InstrF          = instr_s;
   assign predict_taken_F = predict_s;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage producer for the fetch-to-decode pipeline register; drives PCF, PCPlus4F, InstrF and predict_taken_F.
- Holds the PC register and issues the instruction-memory address.
- Predecodes each fetched word (B-type, JAL) and predicts the next PC with a 2-bit-counter branch history table (BHT).
- Accepts redirects and BHT training from the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  fetch enable from the hazard unit; 0 = stall (PC holds).
- redirect_E  input  1  execute stage detected a mispredict; forces a new PC.
- redirect_pc_E  input  32  correct next PC when redirect_E=1.
- bht_update_E  input  1  a resolved B-type branch is in execute; train the BHT.
- bht_pc_E  input  32  PC of that branch.
- bht_taken_E  input  1  actual branch outcome.
- imem_addr  output  32  instruction-memory address; equals PCF.
- imem_rdata  input  32  instruction word, combinationally valid for imem_addr.
- PCF  output  32  current fetch PC.
- PCPlus4F  output  32  PCF + 4.
- InstrF  output  32  fetched instruction.
- predict_taken_F  output  1  fetch predicted the instruction as taken.

Behaviour:
- Reset (rst=0, asynchronous): PCF = RESET_PC; PCPlus4F = RESET_PC+4; all BHT counters = 2'b01 (weakly not-taken).
- While rst=0, InstrF is forced to 32'h0000_0013 (NOP) and predict_taken_F = 0.
- Reset release is synchronous to clk; the first fetch is at RESET_PC.
- Out of reset, InstrF = imem_rdata and imem_addr = PCF, both combinational.
- Predecode, combinational on InstrF:
  - opcode 1100011 is B-type; target = PCF + sign-extended B-immediate.
  - opcode 1101111 is JAL; target = PCF + sign-extended J-immediate.
- BHT index = PC[log2(BHT_ENTRIES)+1:2].
- Prediction:
  - predict_taken_F = JAL, or (B-type and BHT[index of PCF] bit 1 = 1).
  - Any other opcode gives predict_taken_F = 0.
- Next-PC priority, evaluated at each clk edge:
  1. redirect_E=1: PC <= redirect_pc_E. Redirect overrides en=0.
  2. en=0: PC holds.
  3. predict_taken_F=1: PC <= predicted target.
  4. Otherwise: PC <= PCF+4.
- Latency: one cycle from redirect_E to the new PCF. Zero cycles from PCF to InstrF and predict_taken_F.
- All PC arithmetic is modulo 2^32; wrap-around is silent. Targets are not realigned; imem_addr[1:0] is passed as-is.
- BHT update on a clk edge with bht_update_E=1 is a saturating 2-bit counter:
  - taken increments, saturating at 2'b11.
  - not-taken decrements, saturating at 2'b00.
- BHT updates occur regardless of en and redirect_E.
- Same-cycle lookup and update of the same index: the lookup sees the old counter (read-before-write).
- Reset asserted mid-operation discards any in-flight update or redirect. Counters return to 2'b01 and the PC to RESET_PC.

Optional Feature:
- Macro: FETCH_BHT_EN.
- Defined: the BHT and its training path are as described above.
- Undefined:
  - No BHT storage; the bht_* inputs are ignored.
  - B-type prediction is static backward-taken/forward-not-taken: predict taken iff the B-immediate sign bit (InstrF[31]) is 1.
  - JAL is still always taken.

Decomposition:
- Package fetch_pkg holds:
  - opcode constants OPC_BRANCH = 7'b1100011 and OPC_JAL = 7'b1101111.
  - NOP_INSTR = 32'h0000_0013.
  - typedef bht_ctr_t, a 2-bit enum {SNT, WNT, WT, ST}.
  - Immediate-extraction functions imm_b and imm_j.
- One sub-module, branch_history_table: counter array with asynchronous reset, combinational read port, synchronous saturating update port.
  - Instantiated only under FETCH_BHT_EN.

Test Plan:
- Reset, NOP: hold rst=0 with imem_rdata=32'hFFFF_FFFF, then release -> while in reset PCF=0, PCPlus4F=4, InstrF=32'h13, predict_taken_F=0; after release, one cycle per step with NOPs -> PCF=0,4,8.
- JAL: imem_rdata=32'h0100_006F (jal x0,+16) at PCF=8 -> predict_taken_F=1, next PCF=24.
- Stall, redirect priority: en=0 for 3 cycles -> PCF holds. Then en=0 with redirect_E=1 and redirect_pc_E=32'h100 -> next PCF=32'h100.
- BHT training (FETCH_BHT_EN): two bht_update_E with taken=1 for PC 32'h40 -> counter 01 to 11; a beq at 32'h40 is then predicted taken.
  - Then three not-taken updates -> counter 00, prediction not-taken, PCF advances by 4.
- Same-cycle hazard and wrap: beq at PCF=32'h40 with counter 01 while a taken update targets 32'h40 -> predict_taken_F=0 that cycle, counter becomes 10.
  - Separately, PCF=32'hFFFF_FFFC with a NOP -> next PCF=0.
- Static mode (macro undefined): beq with negative offset -> predict_taken_F=1; beq with positive offset -> predict_taken_F=0; bht_update_E has no effect.
